// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined multi-operand ripple-carry adder tree.
// Holds the tree-depth and per-level width helpers plus the result-mode
// constants used by the SAT parameter of rca_pipe_tree.
package rca_pkg;

  // Result modes for the SAT parameter.
  localparam int RCA_WRAP = 0;
  localparam int RCA_SAT  = 1;

  // Number of adder levels needed to reduce nops operands to one (log2).
  function automatic int levels_f(input int nops);
    int l;
    l = 0;
    for (int k = 0; k < 6; k++) begin
      if ((32'sd1 <<< k) < nops) begin
        l = k + 1;
      end else begin
        l = l;
      end
    end
    return l;
  endfunction

  // Width of a partial sum at tree level i: one carry bit gained per level.
  function automatic int lvl_w(input int w, input int i);
    return w + i + 1;
  endfunction

endpackage

// File: rtl/rca_adder.sv
// Parametrised N-bit ripple-carry adder.
// Ports:
//   a, b  in  N : addends
//   cin   in  1 : carry in
//   sum   out N : a + b + cin modulo 2^N
//   cout  out 1 : carry out of the most significant bit
// Each bit is a full-adder cell; the carry of each cell lives in its own
// generate scope so the chain is a set of distinct nets rather than one
// self-referencing vector.
module rca_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  for (genvar k = 0; k < N; k++) begin : g_fa
    logic ci;
    logic co;

    if (k == 0) begin : g_c0
      assign ci = cin;
    end else begin : g_cn
      assign ci = g_fa[k-1].co;
    end

    assign sum[k] = a[k] ^ b[k] ^ ci;
    assign co     = (a[k] & b[k]) | (ci & (a[k] ^ b[k]));
  end

  assign cout = g_fa[N-1].co;

endmodule

// File: rtl/rca_pipe_tree.sv
// Pipelined multi-operand unsigned adder tree with valid/ready handshake.
// Ports:
//   clk        in  1      : clock, rising edge
//   rst        in  1      : synchronous active-high reset
//   in_valid   in  1      : operand set on in_ops is valid
//   in_ready   out 1      : block accepts an operand set this cycle
//   in_ops     in  NOPS*W : operand k at bits [k*W +: W]
//   out_valid  out 1      : out_sum / out_ovf are valid
//   out_ready  in  1      : consumer takes the result this cycle
//   out_sum    out W      : sum, wrapped or clamped depending on SAT
//   out_ovf    out 1      : true sum exceeds 2^W-1
// Level i holds NOPS/2^(i+1) partial sums of width W+i+1. The last level
// registers the already wrapped/saturated result, so outputs come straight
// from flops and the latency stays at log2(NOPS) cycles.
module rca_pipe_tree
  import rca_pkg::*;
#(
  parameter int W    = 4,
  parameter int NOPS = 4,
  parameter int SAT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NOPS*W-1:0] in_ops,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_sum,
  output logic              out_ovf
);

  localparam int L = levels_f(NOPS);

  logic           stall;
  logic [L-1:0]   vld_in;
  logic [L-1:0]   valid_d;
  logic [L-1:0]   valid_q;
  logic [W+L-1:0] final_s;
  logic           ovf_s;
  logic [W-1:0]   out_sum_d;
  logic [W-1:0]   out_sum_q;
  logic           out_ovf_d;
  logic           out_ovf_q;

  // Global stall: the only thing that can block the pipe is a held result.
  always_comb begin
    stall    = valid_q[L-1] & ~out_ready;
    in_ready = ~stall;
  end

  // Valid bits shift one level per advancing edge; bubbles shift too.
  always_comb begin
    vld_in[0] = in_valid;
    for (int i = 1; i < L; i++) begin
      vld_in[i] = valid_q[i-1];
    end
    if (stall) begin
      valid_d = valid_q;
    end else begin
      valid_d = vld_in;
    end
  end

  // Valid-bit pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  for (genvar i = 0; i < L; i++) begin : g_lvl
    localparam int NN = NOPS >> (i + 1);
    localparam int WI = W + i;
    localparam int WO = lvl_w(W, i);

    // Packed operand pairs feeding this level; layout matches in_ops.
    logic [2*NN-1:0][WI-1:0] opnd;
    logic [NN-1:0][WO-1:0]   node_s;

    if (i == 0) begin : g_src
      assign opnd = in_ops;
    end else begin : g_src
      assign opnd = g_lvl[i-1].g_reg.sum_q;
    end

    for (genvar n = 0; n < NN; n++) begin : g_node
      logic [WI-1:0] s;
      logic          co;

      rca_adder #(
        .N(WI)
      ) u_add (
        .a   (opnd[2*n]),
        .b   (opnd[2*n+1]),
        .cin (1'b0),
        .sum (s),
        .cout(co)
      );

      // Carry out becomes the new MSB, so no width is lost in the tree.
      assign node_s[n] = {co, s};
    end

    if (i < L - 1) begin : g_reg
      logic [NN-1:0][WO-1:0] sum_q;
      logic [NN-1:0][WO-1:0] sum_d;

      // Partial sums load only when a valid set advances into this level.
      always_comb begin
        if (!stall && vld_in[i]) begin
          sum_d = node_s;
        end else begin
          sum_d = sum_q;
        end
      end

      // Partial-sum register for this level.
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q <= '0;
        end else begin
          sum_q <= sum_d;
        end
      end
    end else begin : g_out
      assign final_s = node_s[0];
    end
  end

  // Final stage: overflow is any bit above W; optionally clamp to all ones.
  always_comb begin
    ovf_s = |final_s[W+L-1:W];
    if (!stall && vld_in[L-1]) begin
      out_ovf_d = ovf_s;
      if ((SAT == RCA_SAT) && ovf_s) begin
        out_sum_d = '1;
      end else begin
        out_sum_d = final_s[W-1:0];
      end
    end else begin
      out_ovf_d = out_ovf_q;
      out_sum_d = out_sum_q;
    end
  end

  // Output register; holds steady while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_valid = valid_q[L-1];
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_rca_pipe_tree.sv
// Self-checking bench for rca_pipe_tree: three instances (defaults, SAT=1,
// W=8/NOPS=8) sharing one clock, each with its own scoreboard queue.
module tb_rca_pipe_tree;

  typedef struct {
    logic [7:0] sum;
    logic       ovf;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        d_iv, d_ir, d_ov, d_ordy, d_ovf;
  logic [15:0] d_ops;
  logic [3:0]  d_sum;
  logic        s_iv, s_ir, s_ov, s_ordy, s_ovf;
  logic [15:0] s_ops;
  logic [3:0]  s_sum;
  logic        w_iv, w_ir, w_ov, w_ordy, w_ovf;
  logic [63:0] w_ops;
  logic [7:0]  w_sum;

  exp_t q_d[$];
  exp_t q_s[$];
  exp_t q_w[$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic lat_chk = 1'b1;
  logic acc[3];
  logic hold_v[3];
  logic [7:0] hold_sum[3];
  logic hold_ovf[3];

  logic       smp_d_ov, smp_d_ir, smp_d_ovf, smp_s_ov, smp_s_ovf, smp_w_ov, smp_w_ir, smp_w_ovf;
  logic [3:0] smp_d_sum, smp_s_sum;
  logic [7:0] smp_w_sum;

  always #5 clk = ~clk;

  rca_pipe_tree #(.W(4), .NOPS(4), .SAT(0)) u_def (
    .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .in_ops(d_ops),
    .out_valid(d_ov), .out_ready(d_ordy), .out_sum(d_sum), .out_ovf(d_ovf)
  );

  rca_pipe_tree #(.W(4), .NOPS(4), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir), .in_ops(s_ops),
    .out_valid(s_ov), .out_ready(s_ordy), .out_sum(s_sum), .out_ovf(s_ovf)
  );

  rca_pipe_tree #(.W(8), .NOPS(8), .SAT(0)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(w_iv), .in_ready(w_ir), .in_ops(w_ops),
    .out_valid(w_ov), .out_ready(w_ordy), .out_sum(w_sum), .out_ovf(w_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] p4(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  // Reference: plain integer sum of all operands, then wrap or clamp.
  function automatic exp_t model(input logic [63:0] ops, input int w, input int n,
                                 input int sat, input int acc_c);
    exp_t   e;
    longint total;
    longint mask;
    mask  = (longint'(1) << w) - 1;
    total = 0;
    for (int k = 0; k < n; k++) begin
      total += longint'((ops >> (k * w)) & 64'(mask));
    end
    e.ovf = (total > mask);
    e.sum = 8'((sat == 1 && e.ovf) ? mask : (total & mask));
    e.acc = acc_c;
    return e;
  endfunction

  task automatic sb(input int id, input logic iv, input logic ir, input logic ov,
                    input logic ordy, input logic [7:0] sum, input logic ovf,
                    input logic [63:0] ops);
    int   w, n, sat, lat;
    exp_t e;
    logic have;
    case (id)
      0:       begin w = 4; n = 4; sat = 0; lat = 2; end
      1:       begin w = 4; n = 4; sat = 1; lat = 2; end
      default: begin w = 8; n = 8; sat = 0; lat = 3; end
    endcase
    if (hold_v[id] && ov === 1'b1) begin
      chk($sformatf("hold_sum%0d", id), {24'd0, sum}, {24'd0, hold_sum[id]});
      chk($sformatf("hold_ovf%0d", id), {31'd0, ovf}, {31'd0, hold_ovf[id]});
    end
    hold_v[id]   = (ov === 1'b1) && !ordy && !rst;
    hold_sum[id] = sum;
    hold_ovf[id] = ovf;
    acc[id] = (iv && ir === 1'b1 && !rst);
    if (acc[id]) begin
      e = model(ops, w, n, sat, cyc);
      case (id)
        0:       q_d.push_back(e);
        1:       q_s.push_back(e);
        default: q_w.push_back(e);
      endcase
    end
    if (ov === 1'b1 && ordy && !rst) begin
      have = 1'b0;
      case (id)
        0:       if (q_d.size() > 0) begin e = q_d.pop_front(); have = 1'b1; end
        1:       if (q_s.size() > 0) begin e = q_s.pop_front(); have = 1'b1; end
        default: if (q_w.size() > 0) begin e = q_w.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        chk($sformatf("unexpected_out%0d", id), {31'd0, ov}, 32'd0);
      end else begin
        chk($sformatf("sb%0d_sum", id), {24'd0, sum}, {24'd0, e.sum});
        chk($sformatf("sb%0d_ovf", id), {31'd0, ovf}, {31'd0, e.ovf});
        if (lat_chk) begin
          chk($sformatf("sb%0d_latency", id), 32'(cyc - e.acc), 32'(lat));
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sb(0, d_iv, d_ir, d_ov, d_ordy, {4'd0, d_sum}, d_ovf, {48'd0, d_ops});
    sb(1, s_iv, s_ir, s_ov, s_ordy, {4'd0, s_sum}, s_ovf, {48'd0, s_ops});
    sb(2, w_iv, w_ir, w_ov, w_ordy, w_sum, w_ovf, w_ops);
    smp_d_ov = d_ov; smp_d_ir = d_ir; smp_d_sum = d_sum; smp_d_ovf = d_ovf;
    smp_s_ov = s_ov; smp_s_sum = s_sum; smp_s_ovf = s_ovf;
    smp_w_ov = w_ov; smp_w_ir = w_ir; smp_w_sum = w_sum; smp_w_ovf = w_ovf;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [15:0] bp_ops[6];
    int idx;
    int sent;

    for (int i = 0; i < 3; i++) begin
      hold_v[i] = 1'b0;
      acc[i]    = 1'b0;
    end
    rst = 1'b1;
    d_iv = 1'b0; s_iv = 1'b0; w_iv = 1'b0;
    d_ordy = 1'b1; s_ordy = 1'b1; w_ordy = 1'b1;
    d_ops = 16'd0; s_ops = 16'd0; w_ops = 64'd0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_out_valid", {31'd0, smp_d_ov}, 32'd0);
    chk("rst_out_sum", {28'd0, smp_d_sum}, 32'd0);
    chk("rst_out_ovf", {31'd0, smp_d_ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, smp_d_ir}, 32'd1);
    chk("rst_w8_sum", {24'd0, smp_w_sum}, 32'd0);

    // Defaults: two back-to-back sets, latency 2.
    d_iv = 1'b1; d_ops = p4(3, 5, 3, 0);
    cycle();
    d_ops = p4(3, 8, 3, 2);
    cycle();
    chk("t1_not_yet_valid", {31'd0, smp_d_ov}, 32'd0);
    d_iv = 1'b0;
    cycle();
    chk("t1_valid", {31'd0, smp_d_ov}, 32'd1);
    chk("t1_sum", {28'd0, smp_d_sum}, 32'd11);
    chk("t1_ovf", {31'd0, smp_d_ovf}, 32'd0);
    cycle();
    chk("t2_sum", {28'd0, smp_d_sum}, 32'd0);
    chk("t2_ovf", {31'd0, smp_d_ovf}, 32'd1);
    cycle();

    // Same overflowing set into wrap and saturate instances.
    d_iv = 1'b1; d_ops = p4(12, 13, 5, 3);
    s_iv = 1'b1; s_ops = p4(12, 13, 5, 3);
    cycle();
    d_iv = 1'b0; s_iv = 1'b0;
    cycle();
    cycle();
    chk("sat_sum", {28'd0, smp_s_sum}, 32'd15);
    chk("sat_ovf", {31'd0, smp_s_ovf}, 32'd1);
    chk("wrap_sum", {28'd0, smp_d_sum}, 32'd1);
    chk("wrap_ovf", {31'd0, smp_d_ovf}, 32'd1);
    cycle();

    // W=8 NOPS=8 all ones: latency 3.
    w_iv = 1'b1; w_ops = {8{8'hff}};
    cycle();
    w_iv = 1'b0;
    cycle();
    cycle();
    chk("w8_not_yet_valid", {31'd0, smp_w_ov}, 32'd0);
    cycle();
    chk("w8_valid", {31'd0, smp_w_ov}, 32'd1);
    chk("w8_sum", {24'd0, smp_w_sum}, 32'd248);
    chk("w8_ovf", {31'd0, smp_w_ovf}, 32'd1);
    cycle();

    // Backpressure: out_ready low for cycles 3..5 of a 6-set stream.
    lat_chk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bp_ops[i] = 16'($urandom);
    end
    idx = 0;
    for (int n = 0; n < 12; n++) begin
      d_iv   = (idx < 6);
      d_ops  = bp_ops[idx % 6];
      d_ordy = !(n >= 3 && n <= 5);
      cycle();
      chk($sformatf("bp_in_ready_c%0d", n), {31'd0, smp_d_ir}, (n >= 3 && n <= 5) ? 32'd0 : 32'd1);
      if (acc[0]) begin
        idx++;
      end
    end
    d_iv = 1'b0;
    d_ordy = 1'b1;
    chk("bp_sets_sent", 32'(idx), 32'd6);
    chk("bp_drained", 32'(q_d.size()), 32'd0);

    // Reset mid-flight: two accepted sets are discarded.
    d_ordy = 1'b0;
    d_iv = 1'b1; d_ops = p4(1, 1, 1, 1);
    cycle();
    d_ops = p4(2, 2, 2, 2);
    cycle();
    rst = 1'b1; d_ops = p4(4, 4, 4, 4);
    cycle();
    rst = 1'b0; d_iv = 1'b0; d_ordy = 1'b1;
    q_d.delete();
    hold_v[0] = 1'b0;
    cycle();
    chk("mrst_out_valid", {31'd0, smp_d_ov}, 32'd0);
    chk("mrst_out_sum", {28'd0, smp_d_sum}, 32'd0);
    chk("mrst_out_ovf", {31'd0, smp_d_ovf}, 32'd0);
    chk("mrst_in_ready", {31'd0, smp_d_ir}, 32'd1);
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("mrst_no_ghost", {31'd0, smp_d_ov}, 32'd0);
    end

    // An input presented during reset must not be accepted.
    rst = 1'b1; d_iv = 1'b1; d_ops = p4(7, 7, 7, 7);
    cycle();
    rst = 1'b0; d_iv = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("rst_input_dropped", {31'd0, smp_d_ov}, 32'd0);
    end

    // Random stream on the W=8 instance with random backpressure.
    sent = 0;
    for (int n = 0; n < 6000 && sent < 1000; n++) begin
      w_iv   = ($urandom_range(0, 3) != 0);
      w_ops  = {$urandom, $urandom};
      w_ordy = ($urandom_range(0, 3) != 0);
      cycle();
      if (acc[2]) begin
        sent++;
      end
    end
    w_iv = 1'b0;
    w_ordy = 1'b1;
    for (int n = 0; n < 6; n++) begin
      cycle();
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    chk("rand_drained", 32'(q_w.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rca_pipe_tree.md
# rca_pipe_tree

Parametrised, pipelined multi-operand unsigned adder built from ripple-carry stages. It is the successor to the fixed 4-bit, four-input pipelined RCA: operand width and operand count are generic, and it adds a valid/ready handshake with backpressure, an overflow flag and an optional saturating mode. It sits between operand producers and result consumers in the datapath, and it is the reference adder for the HW4 pipeline exercises.

## Interface
Parameters:
- `W`, default 4: operand and result width in bits, range 2..32.
- `NOPS`, default 4: number of operands; must be a power of two, range 2..16.
- `SAT`, default 0: 0 = wrap the result modulo 2^W; 1 = clamp the result to 2^W-1 on overflow.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operand set on `in_ops` is valid.
- `in_ready`  out  1: the block can accept an operand set this cycle.
- `in_ops`  in  NOPS*W: packed operands; operand k occupies bits [k*W +: W].
- `out_valid`  out  1: `out_sum` and `out_ovf` are valid.
- `out_ready`  in  1: the consumer accepts the result this cycle.
- `out_sum`  out  W: sum of all operands, wrapped or saturated per `SAT`.
- `out_ovf`  out  1: the true sum is greater than 2^W-1.

## Operation
- The tree has L = log2(NOPS) levels. Level i holds NOPS/2^(i+1) registered partial sums, each of width W+i+1.
- Each level adds adjacent pairs from the previous level with a ripple-carry adder. No width is lost inside the tree.
- Final stage, applied to the full-width sum S of W+L bits:
  - `out_ovf` = OR of S[W+L-1:W].
  - `out_sum` = S[W-1:0] when SAT=0.
  - `out_sum` = all ones when SAT=1 and the overflow flag is set; otherwise S[W-1:0].
- Each level has a valid bit. The data registers of a level load only when that level advances.
- Global stall: `stall` = `out_valid` and not `out_ready`.
  - When stall is high, no level advances.
  - `in_ready` = not `stall`, computed combinationally.
- Handshake rules:
  - An operand set is accepted on a rising edge where `in_valid` and `in_ready` are both high.
  - A result is consumed on a rising edge where `out_valid` and `out_ready` are both high.
  - An upstream bubble (`in_valid` low with `in_ready` high) propagates as a cleared valid bit. Bubbles are not collapsed.
- `out_sum` and `out_ovf` must hold stable while `out_valid` is high and `out_ready` is low.
- Reset:
  - Every valid bit and every data register clears to 0.
  - After reset, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `in_ready`=1.
- Reset mid-operation:
  - All in-flight operand sets are discarded at the reset edge and produce no output.
  - An input presented in the same cycle as `rst` is not accepted.

## Timing
- Latency: L cycles from the accept edge to the first cycle `out_valid` is high, with no stall. With the defaults (NOPS=4) that is 2 cycles.
- Throughput: one operand set per cycle while `out_ready` stays high.
- A stall held for N cycles delays every in-flight result by exactly N cycles. Order is preserved and nothing is dropped or duplicated.
- Simultaneous consume and accept under a full pipeline: with `out_ready` high, `in_ready` is high. The pipe shifts, the result is consumed and the new set enters in the same edge.
- Output register depth is exactly one. No skid buffer: `in_ready` depends combinationally on `out_ready`.

## Structure
- Shared package `rca_pkg`:
  - constant function `levels_f(NOPS)` returning log2;
  - width helper `lvl_w(W, i)` = W+i+1;
  - SAT mode constants `RCA_WRAP`=0 and `RCA_SAT`=1.
- Sub-module `rca_adder`: parametrised N-bit ripple-carry adder. Inputs a, b, cin; outputs sum, cout. It is built from a generate loop of full-adder cells, and every tree node instantiates it.
- Top level: a generate loop over levels and nodes, the valid/stall logic and the final saturate/overflow stage. Target 150-300 lines total.

## Test plan
- Defaults, `out_ready`=1:
  - ops {3,5,3,0} accepted at cycle t -> `out_valid` at t+2 with `out_sum`=11, `out_ovf`=0.
  - ops {3,8,3,2} back-to-back -> `out_sum`=0, `out_ovf`=1 in the next cycle.
- SAT=1, ops {12,13,5,3} (true sum 33) -> `out_sum`=15, `out_ovf`=1. With SAT=0 the same ops give `out_sum`=1.
- Backpressure: stream 6 sets and hold `out_ready` low for 3 cycles mid-stream.
  - `in_ready` is low for exactly those 3 cycles.
  - Output values are held stable.
  - All 6 results arrive in order with none lost.
- Reset mid-flight: accept 2 sets, assert `rst` for 1 cycle.
  - All outputs read 0 and `in_ready`=1 after that edge.
  - Neither discarded set ever appears.
- W=8, NOPS=8, SAT=0, all ops 255 -> `out_sum`=248 (2040 mod 256), `out_ovf`=1, latency 3. Also run 1000 random sets against a scoreboard computing the sum mod 2^W.
